// File: rtl/sine_dds_quart_if.sv
// Control and sample bundle between the DDS sine generator and its host.
// The slave side is the generator and the master side is the controller/DAC stage.
interface sine_dds_quart_if #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
);
    logic               en_i;
    logic               load_i;
    logic [PHASE_W-1:0] freq_word_i;
    logic [ADDR_W+1:0]  phase_offset_i;
    logic               sync_clr_i;
    logic [DATA_W-1:0]  sample_o;
    logic               valid_o;
    logic [1:0]         quadrant_o;
    logic               wrap_o;

    modport master (
        output en_i, load_i, freq_word_i, phase_offset_i, sync_clr_i,
        input  sample_o, valid_o, quadrant_o, wrap_o
    );

    modport slave (
        input  en_i, load_i, freq_word_i, phase_offset_i, sync_clr_i,
        output sample_o, valid_o, quadrant_o, wrap_o
    );
endinterface

// File: rtl/sine_dds_quart.sv
// Quarter-wave DDS sine generator: phase accumulator, quadrant-folded table
// lookup and a 3-stage registered pipeline producing offset-binary samples.
module sine_dds_quart #(
    parameter int    PHASE_W  = 32,
    parameter int    ADDR_W   = 8,
    parameter int    DATA_W   = 16,
    parameter string ROM_FILE = "sine_quart.hex"
) (
    input  logic                clk,
    input  logic                rst,
    sine_dds_quart_if.slave     bus
);

    localparam int IDX_W = ADDR_W + 2;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [63:0] PI_Q62 = 64'hC90FDAA22168C234;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    // The table is generated at elaboration with the same contents as the ROM_FILE image:
    // floor(2^(DATA_W-1)*(1+sin(i*pi/2^(ADDR_W+1)))) clamped to full scale, via Q62 Taylor series.
    function automatic logic [DATA_W-1:0] quart_entry(input int unsigned idx);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] pos;
        logic [127:0] neg;
        logic [127:0] den;
        logic [127:0] full;
        logic [127:0] max_v;
        x    = (128'(PI_Q62) * 128'(idx)) >> (ADDR_W + 1);
        x2   = (x * x) >> 62;
        term = x;
        pos  = x;
        neg  = 128'd0;
        for (int k = 1; k < 16; k++) begin
            den  = 128'((2 * k) * (2 * k + 1));
            term = ((term * x2) >> 62) / den;
            if ((k % 2) == 1) begin
                neg = neg + term;
            end else begin
                pos = pos + term;
            end
        end
        full  = ((128'd1 << 62) + pos - neg) >> (62 - (DATA_W - 1));
        max_v = (128'd1 << DATA_W) - 128'd1;
        if (full > max_v) begin
            full = max_v;
        end else begin
            full = full;
        end
        return full[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] rom_s [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [DATA_W-1:0] ENTRY = quart_entry(gi);
        assign rom_s[gi] = ENTRY;
    end

    logic [PHASE_W-1:0] acc_q,  acc_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic               wrap_q, wrap_d;
    logic [ADDR_W-1:0]  addr1_q;
    logic [1:0]         quad1_q;
    logic               v1_q;
    logic [DATA_W-1:0]  rom_q;
    logic [1:0]         quad2_q;
    logic               v2_q;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic [1:0]         quad3_q;
    logic               v3_q;

    logic [PHASE_W:0]   sum_s;
    logic [IDX_W-1:0]   phase_s;
    logic [1:0]         quad_s;
    logic [ADDR_W-1:0]  addr_s;

    // Accumulator/frequency next state, phase folding and output inversion.
    always_comb begin
        acc_d    = acc_q;
        wrap_d   = 1'b0;
        freq_d   = freq_q;
        sum_s    = {1'b0, acc_q} + {1'b0, freq_q};
        phase_s  = acc_q[PHASE_W-1 -: IDX_W] + bus.phase_offset_i;
        quad_s   = phase_s[IDX_W-1:ADDR_W];
        addr_s   = phase_s[ADDR_W-1:0];
        sample_d = rom_q;

        if (bus.sync_clr_i) begin
            acc_d = {PHASE_W{1'b0}};
        end else if (bus.en_i) begin
            acc_d  = sum_s[PHASE_W-1:0];
            wrap_d = sum_s[PHASE_W];
        end else begin
            acc_d = acc_q;
        end

        if (bus.load_i) begin
            freq_d = bus.freq_word_i;
        end else begin
            freq_d = freq_q;
        end

        // Odd quadrants walk the quarter table backwards.
        if (quad_s[0]) begin
            addr_s = ~phase_s[ADDR_W-1:0];
        end else begin
            addr_s = phase_s[ADDR_W-1:0];
        end

        // Lower half-cycle mirrors about the midpoint.
        if (quad2_q[1]) begin
            sample_d = ~rom_q;
        end else begin
            sample_d = rom_q;
        end
    end

    // State and pipeline registers; the ROM register resets to the midpoint so the
    // output does not step away from mid-scale while the pipeline refills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= {PHASE_W{1'b0}};
            freq_q   <= {PHASE_W{1'b0}};
            wrap_q   <= 1'b0;
            addr1_q  <= {ADDR_W{1'b0}};
            quad1_q  <= 2'd0;
            v1_q     <= 1'b0;
            rom_q    <= MID;
            quad2_q  <= 2'd0;
            v2_q     <= 1'b0;
            sample_q <= MID;
            quad3_q  <= 2'd0;
            v3_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            freq_q   <= freq_d;
            wrap_q   <= wrap_d;
            addr1_q  <= addr_s;
            quad1_q  <= quad_s;
            v1_q     <= bus.en_i;
            rom_q    <= rom_s[addr1_q];
            quad2_q  <= quad1_q;
            v2_q     <= v1_q;
            sample_q <= sample_d;
            quad3_q  <= quad2_q;
            v3_q     <= v2_q;
        end
    end

    assign bus.sample_o   = sample_q;
    assign bus.valid_o    = v3_q;
    assign bus.quadrant_o = quad3_q;
    assign bus.wrap_o     = wrap_q;

endmodule
